// File: rtl/vga_text_console.sv
// vga_text_console: ASCII byte stream into a scrolling character buffer, rendered through a font ROM to VGA pixels.
module vga_text_console #(
  parameter int COLS = 70,
  parameter int ROWS = 30,
  parameter int GLYPH_W = 9,
  parameter int GLYPH_H = 16,
  parameter logic [23:0] FG = 24'hFFFFFF,
  parameter logic [23:0] BG = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  output logic [7:0]  font_ascii,
  output logic [3:0]  font_row,
  output logic [3:0]  font_col,
  input  logic        font_data,
  output logic [23:0] vga_data,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y
);
  localparam logic [6:0]  XMAX   = 7'(COLS - 1);
  localparam logic [4:0]  YMAX   = 5'(ROWS - 1);
  localparam logic [11:0] NLAST  = 12'(COLS * ROWS - 1);
  localparam logic [11:0] COLS12 = 12'(COLS);
  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_LINE} state_t;
  state_t state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [6:0]  x_q, x_d;
  logic [4:0]  y_q, y_d, top_q, top_d, clr_q, clr_d;
  logic        rdy_q, rdy_d, do_lf;
  logic        we;
  logic [11:0] waddr, raddr;
  logic [7:0]  wdata;
  logic [7:0]  mem [COLS*ROWS];
  logic [6:0]  cx;
  logic [5:0]  cy;
  logic [3:0]  gx, gy;
  logic        area, hit;
  logic [7:0]  fa_q, fa_d;
  logic [3:0]  fr_q, fr_d, fc_q, fc_d;
  logic        area_q, area_d, hit_q, hit_d, val_q, val_d;
  logic [23:0] vga_q, vga_d;

  // Logical row is offset by the scroll origin, wrapping within ROWS.
  function automatic logic [11:0] phys(input logic [4:0] top, input logic [4:0] row, input logic [6:0] col);
    logic [5:0] s;
    s = {1'b0, top} + {1'b0, row};
    s = (s >= 6'(ROWS)) ? s - 6'(ROWS) : s;
    return 12'(s) * COLS12 + 12'(col);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    x_d = x_q;
    y_d = y_q;
    top_d = top_q;
    clr_d = clr_q;
    rdy_d = rdy_q;
    do_lf = 1'b0;
    we = 1'b0;
    waddr = cnt_q;
    wdata = 8'h20;
    case (state_q)
      CLEAR_ALL: begin
        we = 1'b1;
        cnt_d = (cnt_q == NLAST) ? 12'd0 : cnt_q + 12'd1;
        state_d = (cnt_q == NLAST) ? IDLE : CLEAR_ALL;
        rdy_d = (cnt_q == NLAST);
      end
      CLEAR_LINE: begin
        we = 1'b1;
        waddr = 12'(clr_q) * COLS12 + cnt_q;
        cnt_d = (cnt_q == 12'(XMAX)) ? 12'd0 : cnt_q + 12'd1;
        state_d = (cnt_q == 12'(XMAX)) ? IDLE : CLEAR_LINE;
        rdy_d = (cnt_q == 12'(XMAX));
      end
      IDLE: begin
        if (in_valid) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            we = 1'b1;
            waddr = phys(top_q, y_q, x_q);
            wdata = in_char;
            x_d = (x_q == XMAX) ? 7'd0 : x_q + 7'd1;
            do_lf = (x_q == XMAX);
          end else if (in_char == 8'h0A) begin
            x_d = 7'd0;
            do_lf = 1'b1;
          end else if (in_char == 8'h0D) begin
            x_d = 7'd0;
          end else if (in_char == 8'h08 && x_q != 7'd0) begin
            x_d = x_q - 7'd1;
            we = 1'b1;
            waddr = phys(top_q, y_q, x_q - 7'd1);
          end
          // Scrolling retires the old top row, which becomes the new bottom line to blank.
          if (do_lf && y_q != YMAX) begin
            y_d = y_q + 5'd1;
          end else if (do_lf) begin
            top_d = (top_q == YMAX) ? 5'd0 : top_q + 5'd1;
            clr_d = top_q;
            cnt_d = 12'd0;
            state_d = CLEAR_LINE;
            rdy_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = CLEAR_ALL;
        cnt_d = 12'd0;
        rdy_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    cx = 7'(h_addr / 10'(GLYPH_W));
    gx = 4'(h_addr % 10'(GLYPH_W));
    cy = 6'(v_addr / 10'(GLYPH_H));
    gy = 4'(v_addr % 10'(GLYPH_H));
    area = (cx < 7'(COLS)) && (cy < 6'(ROWS));
    hit = (cx == x_q) && (cy == {1'b0, y_q});
    raddr = area ? phys(top_q, cy[4:0], cx) : 12'd0;
    fa_d = mem[raddr];
    fr_d = gy;
    fc_d = gx;
    area_d = area;
    hit_d = hit;
    val_d = 1'b1;
    vga_d = (val_q && area_q && (font_data ^ hit_q)) ? FG : BG;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR_ALL;
      cnt_q <= 12'd0;
      x_q <= 7'd0;
      y_q <= 5'd0;
      top_q <= 5'd0;
      clr_q <= 5'd0;
      rdy_q <= 1'b0;
      fa_q <= 8'd0;
      fr_q <= 4'd0;
      fc_q <= 4'd0;
      area_q <= 1'b0;
      hit_q <= 1'b0;
      val_q <= 1'b0;
      vga_q <= BG;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      top_q <= top_d;
      clr_q <= clr_d;
      rdy_q <= rdy_d;
      fa_q <= fa_d;
      fr_q <= fr_d;
      fc_q <= fc_d;
      area_q <= area_d;
      hit_q <= hit_d;
      val_q <= val_d;
      vga_q <= vga_d;
    end
  end

  assign in_ready = rdy_q;
  assign font_ascii = fa_q;
  assign font_row = fr_q;
  assign font_col = fc_q;
  assign vga_data = vga_q;
  assign cursor_x = x_q;
  assign cursor_y = y_q;
endmodule

// File: tb/tb_vga_text_console.sv
// tb_vga_text_console: directed checks of clearing, byte handling, scrolling and the render pipeline.
module tb_vga_text_console;
  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, font_data, fd_force = 1'b0;
  logic [7:0] in_char = 8'h00, font_ascii;
  logic in_ready;
  logic [9:0] h_addr = 10'd700, v_addr = 10'd0;
  logic [3:0] font_row, font_col;
  logic [23:0] vga_data;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;
  int checks = 0, errors = 0, n, bad;
  logic [23:0] px;
  logic [7:0] fa;
  logic [3:0] fr, fc;

  vga_text_console dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .h_addr(h_addr), .v_addr(v_addr), .font_ascii(font_ascii), .font_row(font_row),
    .font_col(font_col), .font_data(font_data), .vga_data(vga_data),
    .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  // Toy font: every non-space glyph is solid, spaces are empty.
  assign font_data = fd_force | (font_ascii != 8'h20);
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!in_ready && cnt < 5000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic send(input logic [7:0] c);
    int w;
    wait_ready(w);
    if (w >= 5000) chk("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_char = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pix(input int h, input int v);
    h_addr = 10'(h);
    v_addr = 10'(v);
    @(posedge clk);
    #1;
    fa = font_ascii;
    fr = font_row;
    fc = font_col;
    @(posedge clk);
    #1;
    px = vga_data;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_vga", vga_data, BG);
    chk("rst_font", {font_ascii, font_row, font_col}, 32'd0);
    chk("rst_cursor", {cursor_x, cursor_y}, 32'd0);
    rst = 1'b0;
    wait_ready(n);
    chk("clear_all_len", n, 2100);
    bad = 0;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 70; x++) begin
        pix(x * 9 + 4, y * 16 + 7);
        if (px !== ((x == 0 && y == 0) ? FG : BG)) bad++;
      end
    chk("scan_blank", bad, 0);

    send(8'h41);
    chk("a_cursor", {cursor_x, cursor_y}, {7'd1, 5'd0});
    pix(2, 5);
    chk("a_font", {fa, fr, fc}, {8'h41, 4'd5, 4'd2});
    chk("a_vga", px, FG);
    pix(12, 0);
    chk("cursor_inv", px, FG);
    pix(20, 0);
    chk("blank_cell", px, BG);

    send(8'h0D);
    chk("cr", {cursor_x, cursor_y}, {7'd0, 5'd0});
    for (int i = 0; i < 70; i++) send(8'h42);
    chk("wrap", {cursor_x, cursor_y}, {7'd0, 5'd1});
    pix(629, 0);
    chk("b_font", {fa, fc}, {8'h42, 4'd8});
    send(8'h43);
    chk("c_cursor", {cursor_x, cursor_y}, {7'd1, 5'd1});
    send(8'h08);
    chk("bs_cursor", {cursor_x, cursor_y}, {7'd0, 5'd1});
    pix(0, 16);
    chk("bs_cell", fa, 8'h20);
    chk("bs_vga", px, FG);
    send(8'h08);
    chk("bs_at0", {cursor_x, cursor_y}, {7'd0, 5'd1});

    send(8'h58);
    for (int i = 0; i < 28; i++) send(8'h0A);
    chk("lf_cursor", {cursor_x, cursor_y}, {7'd0, 5'd29});
    chk("lf_ready", 32'(in_ready), 32'd1);
    send(8'h5A);
    send(8'h0A);
    chk("scroll_busy", 32'(in_ready), 32'd0);
    wait_ready(n);
    chk("clear_line_len", n, 70);
    chk("scroll_cursor", {cursor_x, cursor_y}, {7'd0, 5'd29});
    pix(0, 0);
    chk("row1_to_row0", fa, 8'h58);
    pix(0, 28 * 16);
    chk("row29_to_row28", fa, 8'h5A);
    bad = 0;
    for (int x = 0; x < 70; x++) begin
      pix(x * 9, 29 * 16 + 3);
      if (fa !== 8'h20) bad++;
    end
    chk("bottom_cleared", bad, 0);

    fd_force = 1'b1;
    pix(635, 0);
    chk("h635_bg", px, BG);
    pix(630, 100);
    chk("h630_bg", px, BG);
    pix(629, 0);
    chk("h629_fg", px, FG);
    pix(0, 479);
    chk("v479_cursor", px, BG);
    fd_force = 1'b0;

    send(8'h0A);
    repeat (30) @(posedge clk);
    #1;
    chk("mid_clear_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst2_cursor", {cursor_x, cursor_y}, 32'd0);
    chk("rst2_vga", vga_data, BG);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready(n);
    chk("rst2_clear_len", n, 2100);
    send(8'h07);
    chk("bel_cursor", {cursor_x, cursor_y}, 32'd0);
    chk("bel_ready", 32'(in_ready), 32'd1);
    pix(4, 7);
    chk("bel_cell", fa, 8'h20);
    chk("bel_vga", px, FG);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
